// File: rtl/seq_key_pkg.sv
// Shared types and helpers for the sequence-key unlock block.
// Holds the lock state enum and the 8-bit keystream LFSR step function.
package seq_key_pkg;

    typedef enum logic {
        LOCKED   = 1'b0,
        UNLOCKED = 1'b1
    } state_t;

    // Feedback taps for x^8+x^6+x^5+x^4+1 in a shift-left register: bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/seq_key_lfsr.sv
// 8-bit keystream register: reloads the seed on load, otherwise steps on adv.
// Reset also returns it to the seed so a fresh unlock always starts identically.
module seq_key_lfsr
    import seq_key_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       adv,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (adv) begin
            q <= lfsr8_next(q);
        end
    end

endmodule

// File: rtl/seq_key_unlock.sv
// Address-sequence key: unlocks after a programmed series of in-window reads,
// then serves one keystream bit per read. Optional idle relock: SEQ_KEY_TIMEOUT_EN.
module seq_key_unlock
    import seq_key_pkg::*;
#(
    parameter int                          SEQ_LEN     = 4,
    parameter int                          FIELD_W     = 4,
    parameter int                          FIELD_LSB   = 4,
    parameter int                          AW          = 14,
    parameter logic [1:0]                  WIN_HI      = 2'b01,
    parameter logic [SEQ_LEN*FIELD_W-1:0]  SEQ         = {4'h5, 4'hA, 4'h3, 4'hC},
    parameter logic [FIELD_W-1:0]          CLOSE_FIELD = 4'hF,
    parameter logic [7:0]                  LFSR_SEED   = 8'hA5,
    parameter int                          TIMEOUT     = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bus_stb,
    input  logic                       sser_n,
    input  logic                       br_w,
    input  logic [AW-1:0]              addr,
    output logic                       sdrd,
    output logic                       sdrd_oe,
    output logic                       unlocked,
    output logic [$clog2(SEQ_LEN)-1:0] step
);

    localparam int SW = $clog2(SEQ_LEN);

    state_t               state_q, state_d;
    logic [SW-1:0]        step_d;
    logic                 sdrd_d, sdrd_oe_d;
    logic                 lfsr_load, lfsr_adv;
    logic [7:0]           lfsr_q;
    logic [FIELD_W-1:0]   field;
    logic                 win_hit, qa;
    logic [FIELD_W-1:0]   seq_tab [SEQ_LEN];
    logic                 unused_addr;

    // Step 0 lives in the most significant field of SEQ
    for (genvar i = 0; i < SEQ_LEN; i++) begin : g_seq_tab
        assign seq_tab[i] = SEQ[(SEQ_LEN-1-i)*FIELD_W +: FIELD_W];
    end

    assign win_hit     = bus_stb & ~sser_n & (addr[AW-1 -: 2] == WIN_HI);
    assign qa          = win_hit & br_w;
    assign field       = addr[FIELD_LSB +: FIELD_W];
    assign unlocked    = (state_q == UNLOCKED);
    assign unused_addr = ^addr;

    seq_key_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .adv  (lfsr_adv),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

`ifdef SEQ_KEY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          timeout_hit;

    assign timeout_hit = (idle_q == TW'(TIMEOUT));
    assign idle_d      = (qa || timeout_hit) ? '0 : idle_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        step_d    = step;
        sdrd_d    = sdrd;
        sdrd_oe_d = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            LOCKED: begin
                if (qa) begin
                    sdrd_oe_d = 1'b1;
                    sdrd_d    = ^step;
                    if (field == seq_tab[step]) begin
                        if (step == SW'(SEQ_LEN - 1)) begin
                            state_d   = UNLOCKED;
                            step_d    = '0;
                            lfsr_load = 1'b1;
                        end else begin
                            step_d = step + SW'(1);
                        end
                    end else if (field == seq_tab[0]) begin
                        // A mismatching read may itself begin a new attempt
                        step_d = SW'(1);
                    end else begin
                        step_d = '0;
                    end
                end else if (win_hit) begin
                    step_d = '0;
                end
            end
            UNLOCKED: begin
                if (qa) begin
                    sdrd_oe_d = 1'b1;
                    sdrd_d    = lfsr_q[0];
                    if (field == CLOSE_FIELD) begin
                        state_d = LOCKED;
                        step_d  = '0;
                    end else begin
                        lfsr_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOCKED;
                step_d  = '0;
            end
        endcase

`ifdef SEQ_KEY_TIMEOUT_EN
        if (!qa && timeout_hit) begin
            state_d = LOCKED;
            step_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOCKED;
            step    <= '0;
            sdrd    <= 1'b0;
            sdrd_oe <= 1'b0;
        end else begin
            state_q <= state_d;
            step    <= step_d;
            sdrd    <= sdrd_d;
            sdrd_oe <= sdrd_oe_d;
        end
    end

endmodule

// File: tb/tb_seq_key_unlock.sv
// Randomised self-checking bench for seq_key_unlock (default build) against
// an integer-level reference model of the unlock/keystream rules.
module tb_seq_key_unlock;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_stb;
    logic        sser_n;
    logic        br_w;
    logic [13:0] addr;
    logic        sdrd;
    logic        sdrd_oe;
    logic        unlocked;
    logic [1:0]  step;

    int n_compared   = 0;
    int n_mismatched = 0;

    int seq_fields [4] = '{5, 10, 3, 12};

    bit m_unlocked;
    int m_step;
    int m_lfsr;
    bit m_sdrd;
    bit m_oe;

    seq_key_unlock dut (
        .clk      (clk),
        .rst      (rst),
        .bus_stb  (bus_stb),
        .sser_n   (sser_n),
        .br_w     (br_w),
        .addr     (addr),
        .sdrd     (sdrd),
        .sdrd_oe  (sdrd_oe),
        .unlocked (unlocked),
        .step     (step)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lfsrStep(input int x);
        int fb;
        fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
        return ((x * 2) % 256) + fb;
    endfunction

    // Reference model: advance one clock given the inputs seen at that edge
    task automatic modelEdge(input bit r, input bit stb, input bit ssn,
                             input bit brw, input logic [13:0] a);
        bit hit;
        int f;
        if (r) begin
            m_unlocked = 0; m_step = 0; m_lfsr = 165; m_sdrd = 0; m_oe = 0;
            return;
        end
        m_oe = 0;
        hit  = stb && !ssn && (int'(a) / 4096 == 1);
        f    = (int'(a) / 16) % 16;
        if (hit && brw) begin
            m_oe = 1;
            if (m_unlocked) begin
                m_sdrd = m_lfsr % 2;
                if (f == 15) m_unlocked = 0;
                else         m_lfsr = lfsrStep(m_lfsr);
            end else begin
                m_sdrd = $countones(m_step) % 2;
                if (f == seq_fields[m_step]) begin
                    if (m_step == 3) begin
                        m_unlocked = 1; m_step = 0; m_lfsr = 165;
                    end else begin
                        m_step++;
                    end
                end else begin
                    m_step = (f == seq_fields[0]) ? 1 : 0;
                end
            end
        end else if (hit && !m_unlocked) begin
            m_step = 0;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit stb, input bit ssn,
                                 input bit brw, input logic [13:0] a);
        @(negedge clk);
        rst = r; bus_stb = stb; sser_n = ssn; br_w = brw; addr = a;
        modelEdge(r, stb, ssn, brw, a);
        @(posedge clk);
        #1;
        checkOutput("sdrd_oe", int'(sdrd_oe), int'(m_oe));
        checkOutput("unlocked", int'(unlocked), int'(m_unlocked));
        checkOutput("step", int'(step), m_step);
        checkOutput("sdrd", int'(sdrd), int'(m_sdrd));
    endtask

    function automatic logic [13:0] mkAddr(input logic [1:0] win, input int f);
        logic [13:0] a;
        a = 14'($urandom);
        a[13:12] = win;
        a[7:4]   = 4'(f);
        return a;
    endfunction

    task automatic readField(input int f);
        applyStimulus(0, 1, 0, 1, mkAddr(2'b01, f));
    endtask

    task automatic writeField(input int f);
        applyStimulus(0, 1, 0, 0, mkAddr(2'b01, f));
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 1, mkAddr(2'b01, 0));
    endtask

    initial begin
        int roll;
        int f;
        rst = 1'b1; bus_stb = 1'b0; sser_n = 1'b1; br_w = 1'b0; addr = '0;
        applyStimulus(1, 0, 1, 0, '0);
        applyStimulus(1, 1, 0, 1, mkAddr(2'b01, 5));
        checkOutput("reset_unlocked", int'(unlocked), 0);
        checkOutput("reset_step", int'(step), 0);

        // Plain unlock, then keystream reads
        readField(5); readField(10); readField(3); readField(12);
        checkOutput("unlock_seen", int'(unlocked), 1);
        for (int i = 0; i < 4; i++) readField(0);
        readField(15);
        checkOutput("closed", int'(unlocked), 0);

        // Mismatch with restart
        readField(5); readField(10); readField(5); readField(10);
        readField(3); readField(12);
        readField(15);

        // Window write clears, outside-window and deselected strobes ignored
        readField(5); writeField(10); readField(10); readField(3); readField(12);
        checkOutput("write_clears", int'(unlocked), 0);
        readField(5);
        applyStimulus(0, 1, 0, 1, mkAddr(2'b10, 10));
        applyStimulus(0, 1, 1, 1, mkAddr(2'b01, 7));
        readField(10);
        checkOutput("outwin_keeps_step", int'(step), 2);

        // Reset wins over a same-cycle matching read
        applyStimulus(1, 1, 0, 1, mkAddr(2'b01, 3));
        checkOutput("midreset_step", int'(step), 0);

        // Random traffic biased toward progressing the sequence
        for (int n = 0; n < 800; n++) begin
            roll = $urandom_range(0, 99);
            if (!m_unlocked) begin
                if ($urandom_range(0, 99) < 55) f = seq_fields[m_step];
                else if ($urandom_range(0, 99) < 30) f = 5;
                else f = $urandom_range(0, 15);
            end else begin
                f = ($urandom_range(0, 99) < 8) ? 15 : $urandom_range(0, 15);
            end
            if (roll < 2)       applyStimulus(1, $urandom_range(0, 1), 0, 1, mkAddr(2'b01, f));
            else if (roll < 62) readField(f);
            else if (roll < 70) writeField(f);
            else if (roll < 78) applyStimulus(0, 1, 0, 1, mkAddr(2'(roll % 4 == 1 ? 2 : roll % 4), f));
            else if (roll < 84) applyStimulus(0, 1, 1, $urandom_range(0, 1), mkAddr(2'b01, f));
            else                idleCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
